// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, ten data/parity/stop
// bits clocked by the device, then acknowledge and bus-idle check, with timeout.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5_000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t            state, state_nxt;
    logic [8:0]        shift, shift_nxt;
    logic [3:0]        bit_cnt, bit_cnt_nxt;
    logic [INH_W-1:0]  inh_cnt, inh_cnt_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic              clk_q;
    logic              fall;
    logic              to_hit;
    logic              clk_oe_nxt, data_oe_nxt, busy_nxt, done_nxt, err_nxt;

    assign fall   = clk_q & ~ps2_clk_in;
    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            clk_q       <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift       <= shift_nxt;
            bit_cnt     <= bit_cnt_nxt;
            inh_cnt     <= inh_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            clk_q       <= ps2_clk_in;
            ps2_clk_oe  <= clk_oe_nxt;
            ps2_data_oe <= data_oe_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        inh_cnt_nxt = inh_cnt;
        to_cnt_nxt  = to_cnt;
        clk_oe_nxt  = ps2_clk_oe;
        data_oe_nxt = ps2_data_oe;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        unique case (state)
            IDLE: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                if (start) begin
                    shift_nxt   = {1'b1, ~^data, data};
                    busy_nxt    = 1'b1;
                    clk_oe_nxt  = 1'b1;
                    inh_cnt_nxt = '0;
                    state_nxt   = INHIBIT;
                end
            end

            INHIBIT: begin
                if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_nxt = 1'b1;
                    state_nxt   = RTS;
                end else begin
                    inh_cnt_nxt = inh_cnt + 1'b1;
                end
            end

            RTS: begin
                clk_oe_nxt  = 1'b0;
                bit_cnt_nxt = '0;
                to_cnt_nxt  = '0;
                state_nxt   = SEND;
            end

            SEND: begin
                if (fall) begin
                    data_oe_nxt = ~shift[0];
                    shift_nxt   = {1'b1, shift[8:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    to_cnt_nxt  = '0;
                    if (bit_cnt == 4'd9)
                        state_nxt = ACK;
                end else if (to_hit) begin
                    state_nxt   = IDLE;
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b0;
                    busy_nxt    = 1'b0;
                    err_nxt     = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end

            ACK: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                // Device acknowledges by holding data low across the 11th fall.
                if (fall) begin
                    to_cnt_nxt = '0;
                    if (ps2_data_in) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = WAIT_IDLE;
                    end
                end else if (to_hit) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    err_nxt   = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end

            WAIT_IDLE: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                if (ps2_clk_in && ps2_data_in) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else if (fall) begin
                    to_cnt_nxt = '0;
                end else if (to_hit) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    err_nxt   = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt   = IDLE;
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                busy_nxt    = 1'b0;
            end
        endcase
    end

endmodule
